// File: rtl/rice_core_trap_ctrl_if.sv
// rtl/rice_core_trap_ctrl_if.sv - execute-stage event, interrupt and CSR port of the trap controller
interface rice_core_trap_ctrl_if #(
  parameter int XLEN    = 32,
  parameter int NUM_IRQ = 4
);
  logic               i_exception_valid;
  logic [3:0]         i_exception_code;
  logic [XLEN-1:0]    i_exception_tval;
  logic               i_mret;
  logic [XLEN-1:0]    i_pc;
  logic [NUM_IRQ-1:0] i_irq;
  logic               o_irq_req;
  logic               i_irq_ack;
  logic               i_csr_valid;
  logic               i_csr_write;
  logic [11:0]        i_csr_addr;
  logic [XLEN-1:0]    i_csr_wdata;
  logic [XLEN-1:0]    o_csr_rdata;
  logic               o_csr_illegal;
  logic [1:0]         o_privilege_level;
  logic               o_redirect_valid;
  logic [XLEN-1:0]    o_redirect_pc;
  logic [XLEN-1:0]    o_return_pc;

  modport master (
    output i_exception_valid, i_exception_code, i_exception_tval, i_mret, i_pc,
    output i_irq, i_irq_ack, i_csr_valid, i_csr_write, i_csr_addr, i_csr_wdata,
    input  o_irq_req, o_csr_rdata, o_csr_illegal, o_privilege_level,
    input  o_redirect_valid, o_redirect_pc, o_return_pc
  );

  modport slave (
    input  i_exception_valid, i_exception_code, i_exception_tval, i_mret, i_pc,
    input  i_irq, i_irq_ack, i_csr_valid, i_csr_write, i_csr_addr, i_csr_wdata,
    output o_irq_req, o_csr_rdata, o_csr_illegal, o_privilege_level,
    output o_redirect_valid, o_redirect_pc, o_return_pc
  );
endinterface

// File: rtl/rice_core_trap_ctrl.sv
// rtl/rice_core_trap_ctrl.sv - machine-mode trap controller: privilege, trap CSRs and PC redirect
module rice_core_trap_ctrl #(
  parameter int              XLEN        = 32,
  parameter int              NUM_IRQ     = 4,
  parameter logic [XLEN-1:0] MTVEC_RESET = '0
) (
  input logic                  i_clk,
  input logic                  i_rst_n,
  rice_core_trap_ctrl_if.slave bus
);
  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MIE     = 12'h304;
  localparam logic [11:0] ADDR_MTVEC   = 12'h305;
  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
  localparam logic [11:0] ADDR_MTVAL   = 12'h343;
  localparam logic [11:0] ADDR_MIP     = 12'h344;
  localparam logic [1:0]  PRIV_M       = 2'b11;
  localparam logic [1:0]  PRIV_U       = 2'b00;

  logic [1:0]         priv_q, priv_d;
  logic               st_mie_q, st_mie_d;
  logic               st_mpie_q, st_mpie_d;
  logic [1:0]         st_mpp_q, st_mpp_d;
  logic [NUM_IRQ-1:0] mie_q, mie_d;
  logic [XLEN-3:0]    mtvec_base_q, mtvec_base_d;
  logic               mtvec_mode_q, mtvec_mode_d;
  logic [XLEN-1:0]    mepc_q, mepc_d;
  logic               mcause_intr_q, mcause_intr_d;
  logic [4:0]         mcause_code_q, mcause_code_d;
  logic [XLEN-1:0]    mtval_q, mtval_d;
  logic               redir_valid_q, redir_valid_d;
  logic [XLEN-1:0]    redir_pc_q, redir_pc_d;

  logic [NUM_IRQ-1:0] pend;
  logic               irq_req;
  logic [4:0]         irq_code;
  logic               csr_hit;
  logic               csr_illegal;
  logic [XLEN-1:0]    csr_rdata;
  logic               take_exc, take_ack, take_mret;
  logic [XLEN-1:0]    trap_base;

  // Pending/enabled interrupt request and the lowest-index cause code
  always_comb begin
    pend     = bus.i_irq & mie_q;
    irq_req  = (|pend) && (st_mie_q || priv_q == PRIV_U);
    irq_code = 5'd16;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (pend[i]) irq_code = 5'(16 + i);
    end
  end

  // CSR address decode, legality and read mux from current register state
  always_comb begin
    csr_hit   = 1'b1;
    csr_rdata = '0;
    case (bus.i_csr_addr)
      ADDR_MSTATUS: begin
        csr_rdata[3]     = st_mie_q;
        csr_rdata[7]     = st_mpie_q;
        csr_rdata[12:11] = st_mpp_q;
      end
      ADDR_MIE:    csr_rdata[16 +: NUM_IRQ] = mie_q;
      ADDR_MTVEC:  csr_rdata = {mtvec_base_q, 1'b0, mtvec_mode_q};
      ADDR_MEPC:   csr_rdata = mepc_q;
      ADDR_MCAUSE: begin
        csr_rdata[XLEN-1] = mcause_intr_q;
        csr_rdata[4:0]    = mcause_code_q;
      end
      ADDR_MTVAL:  csr_rdata = mtval_q;
      ADDR_MIP:    csr_rdata[16 +: NUM_IRQ] = bus.i_irq;
      default:     csr_hit = 1'b0;
    endcase
    csr_illegal = bus.i_csr_valid && (!csr_hit || priv_q == PRIV_U);
  end

  // Next state: CSR write first, then trap/mret overrides the fields it owns
  always_comb begin
    priv_d        = priv_q;
    st_mie_d      = st_mie_q;
    st_mpie_d     = st_mpie_q;
    st_mpp_d      = st_mpp_q;
    mie_d         = mie_q;
    mtvec_base_d  = mtvec_base_q;
    mtvec_mode_d  = mtvec_mode_q;
    mepc_d        = mepc_q;
    mcause_intr_d = mcause_intr_q;
    mcause_code_d = mcause_code_q;
    mtval_d       = mtval_q;
    redir_valid_d = 1'b0;
    redir_pc_d    = redir_pc_q;
    trap_base     = {mtvec_base_q, 2'b00};

    if (bus.i_csr_valid && bus.i_csr_write && !csr_illegal) begin
      case (bus.i_csr_addr)
        ADDR_MSTATUS: begin
          st_mie_d  = bus.i_csr_wdata[3];
          st_mpie_d = bus.i_csr_wdata[7];
          if (bus.i_csr_wdata[12:11] == PRIV_M || bus.i_csr_wdata[12:11] == PRIV_U)
            st_mpp_d = bus.i_csr_wdata[12:11];
        end
        ADDR_MIE:    mie_d = bus.i_csr_wdata[16 +: NUM_IRQ];
        ADDR_MTVEC: begin
          mtvec_base_d = bus.i_csr_wdata[XLEN-1:2];
          if (!bus.i_csr_wdata[1]) mtvec_mode_d = bus.i_csr_wdata[0];
        end
        ADDR_MEPC:   mepc_d = bus.i_csr_wdata & ~XLEN'(3);
        ADDR_MCAUSE: begin
          mcause_intr_d = bus.i_csr_wdata[XLEN-1];
          mcause_code_d = bus.i_csr_wdata[4:0];
        end
        ADDR_MTVAL:  mtval_d = bus.i_csr_wdata;
        default: ;
      endcase
    end

    // Events are ignored while the previous redirect is still being issued
    take_exc  = bus.i_exception_valid && !redir_valid_q;
    take_ack  = bus.i_irq_ack && irq_req && !redir_valid_q && !take_exc;
    take_mret = bus.i_mret && !redir_valid_q && !take_exc && !take_ack;

    if (take_exc || take_ack) begin
      mepc_d        = bus.i_pc & ~XLEN'(3);
      mcause_intr_d = take_ack;
      mcause_code_d = take_ack ? irq_code : {1'b0, bus.i_exception_code};
      mtval_d       = take_ack ? '0 : bus.i_exception_tval;
      st_mpie_d     = st_mie_q;
      st_mie_d      = 1'b0;
      st_mpp_d      = priv_q;
      priv_d        = PRIV_M;
      redir_valid_d = 1'b1;
      redir_pc_d    = (take_ack && mtvec_mode_q)
                    ? trap_base + XLEN'({irq_code, 2'b00}) : trap_base;
    end else if (take_mret) begin
      st_mie_d      = st_mpie_q;
      st_mpie_d     = 1'b1;
      priv_d        = st_mpp_q;
      st_mpp_d      = PRIV_U;
      redir_valid_d = 1'b1;
      redir_pc_d    = mepc_q;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      priv_q        <= PRIV_M;
      st_mie_q      <= 1'b0;
      st_mpie_q     <= 1'b0;
      st_mpp_q      <= PRIV_U;
      mie_q         <= '0;
      mtvec_base_q  <= MTVEC_RESET[XLEN-1:2];
      mtvec_mode_q  <= (MTVEC_RESET[1:0] == 2'b01);
      mepc_q        <= '0;
      mcause_intr_q <= 1'b0;
      mcause_code_q <= '0;
      mtval_q       <= '0;
      redir_valid_q <= 1'b0;
      redir_pc_q    <= '0;
    end else begin
      priv_q        <= priv_d;
      st_mie_q      <= st_mie_d;
      st_mpie_q     <= st_mpie_d;
      st_mpp_q      <= st_mpp_d;
      mie_q         <= mie_d;
      mtvec_base_q  <= mtvec_base_d;
      mtvec_mode_q  <= mtvec_mode_d;
      mepc_q        <= mepc_d;
      mcause_intr_q <= mcause_intr_d;
      mcause_code_q <= mcause_code_d;
      mtval_q       <= mtval_d;
      redir_valid_q <= redir_valid_d;
      redir_pc_q    <= redir_pc_d;
    end
  end

  assign bus.o_irq_req         = irq_req;
  assign bus.o_csr_rdata       = csr_rdata;
  assign bus.o_csr_illegal     = csr_illegal;
  assign bus.o_privilege_level = priv_q;
  assign bus.o_redirect_valid  = redir_valid_q;
  assign bus.o_redirect_pc     = redir_pc_q;
  assign bus.o_return_pc       = mepc_q;
endmodule

// File: doc/rice_core_trap_ctrl.md
# rice_core_trap_ctrl

Machine-mode trap controller for the rice core, parametrised in XLEN and local interrupt count. It owns the privilege level and the trap CSRs: mstatus, mie, mip, mtvec, mepc, mcause and mtval. It accepts exception, interrupt-acknowledge and mret events from the execute stage, and issues a registered PC redirect one cycle later. Unlike the earlier env interface, it adds vectored mtvec, a local interrupt handshake and a CSR access port.

## Interface
- XLEN, 32: data/PC width, 32 or 64.
- NUM_IRQ, 4: local interrupt lines, 1..16, mapped to cause codes 16..16+NUM_IRQ-1.
- MTVEC_RESET, 0: reset value of mtvec, MODE field = 0.
- i_clk  in  1  clock.
- i_rst_n  in  1  reset; synchronous, active-low.
- i_exception_valid  in  1  exception event for the instruction at i_pc.
- i_exception_code  in  4  exception cause code.
- i_exception_tval  in  XLEN  value captured into mtval.
- i_mret  in  1  mret retiring.
- i_pc  in  XLEN  PC of the event instruction.
- i_irq  in  NUM_IRQ  level-sensitive local interrupts.
- o_irq_req  out  1  interrupt pending and enabled.
- i_irq_ack  in  1  execute stage converts the instruction at i_pc into an interrupt trap.
- i_csr_valid  in  1  CSR access.
- i_csr_write  in  1  write enable.
- i_csr_addr  in  12  CSR address.
- i_csr_wdata  in  XLEN  write data.
- o_csr_rdata  out  XLEN  read data, combinational.
- o_csr_illegal  out  1  access is illegal, combinational.
- o_privilege_level  out  2  2'b11 = M, 2'b00 = U.
- o_redirect_valid  out  1  one-cycle redirect pulse.
- o_redirect_pc  out  XLEN  redirect target.
- o_return_pc  out  XLEN  current mepc.

## Operation
- **CSR map**
  - 0x300 mstatus: only MIE[3], MPIE[7] and MPP[12:11] are writable. MPP accepts only 00 or 11; any other value leaves MPP unchanged. All other bits read 0.
  - 0x304 mie: bits 16..16+NUM_IRQ-1 are writable.
  - 0x305 mtvec: BASE is [XLEN-1:2], MODE is [1:0]. MODE accepts 0 or 1; values 2 or 3 leave MODE unchanged.
  - 0x341 mepc: bits [1:0] are forced to 0.
  - 0x342 mcause: bit XLEN-1 is the interrupt flag, bits [4:0] are the code.
  - 0x343 mtval.
  - 0x344 mip: read-only view of i_irq at bits 16+; writes are ignored.
- **o_csr_illegal** asserts when i_csr_valid is high and either condition holds:
  - the address is unmapped;
  - the current privilege is U.
- Illegal accesses have no side effects.
- **Pending set**: pend = i_irq & mie[16+:NUM_IRQ].
  - o_irq_req = |pend && (mstatus.MIE || privilege == U).
  - Priority goes to the lowest index. The code taken is 16 + that index, evaluated in the i_irq_ack cycle.
- **Trap** (exception or ack):
  - mepc ← {i_pc[XLEN-1:2], 2'b00}.
  - mcause ← code, with the interrupt flag set for ack.
  - mtval ← i_exception_tval for an exception, 0 for an interrupt.
  - MPIE ← MIE, MIE ← 0, MPP ← privilege, privilege ← M.
- **mret**:
  - MIE ← MPIE, MPIE ← 1.
  - privilege ← MPP, MPP ← U.
- **Target selection**:
  - Trap target is BASE<<2 when MODE = 0 or for an exception.
  - Trap target is (BASE<<2) + 4×code for an interrupt when MODE = 1.
  - mret target is the pre-update mepc.
- **Event priority**, when events coincide: exception > ack > mret. Lower-priority events in the same cycle are dropped.
- A trap or mret updates the same CSR fields as a simultaneous CSR write; the trap/mret update wins those fields. A CSR write to any other field still takes effect.
- i_irq_ack while o_irq_req = 0 is ignored.

## Timing
- Reset values:
  - o_privilege_level = 2'b11.
  - mstatus, mie, mepc, mcause and mtval = 0.
  - mtvec = MTVEC_RESET.
  - o_redirect_valid = 0, o_redirect_pc = 0.
  - o_irq_req = 0 (follows from mie = 0).
- Reset applied mid-redirect clears o_redirect_valid on the next edge.
- CSR reads are combinational and reflect state before the current edge.
- CSR and trap-state updates take effect at the edge that samples the event.
- o_redirect_valid is a one-cycle pulse in the cycle after the event edge, with o_redirect_pc held until the next event.
- During the redirect-pulse cycle, all event inputs (exception, ack, mret) are ignored.
- o_privilege_level and o_return_pc are registered. They show new values from the cycle after the event.
- o_irq_req is combinational from registers and i_irq. It responds in the same cycle i_irq changes.

## Test plan
- **Reset**: release reset → privilege 11; mtvec reads MTVEC_RESET; o_irq_req = 0; no redirect pulse.
- **Exception, then mret**:
  - Setup: privilege U, mtvec = 0x100.
  - Stimulus: exception code 2, pc = 0x2004, tval = 0xDEAD.
  - Required next cycle: redirect to 0x100; mepc = 0x2004; mcause = 2; mtval = 0xDEAD; privilege M; MPP = 00.
  - Then mret → redirect to 0x2004; privilege U.
- **Vectored interrupt**:
  - Setup: mtvec = 0x101, mie bit 17 set, MIE = 1, i_irq = 4'b0110.
  - Required: o_irq_req = 1.
  - Stimulus: ack at pc = 0x400.
  - Required: mcause = 0x8000_0011; redirect to 0x144; MIE = 0; o_irq_req drops.
- **Simultaneous events**: exception and mret in the same cycle → exception taken; target is mtvec; mret dropped.
- **CSR legality**:
  - U-mode read of 0x300 → o_csr_illegal = 1.
  - Write of 0x3 to mtvec MODE → MODE unchanged.
  - Write to mip → ignored.
  - Read of 0x7C0 → illegal.
- **Back-to-back events**: exception, then another exception in the next (redirect-pulse) cycle → the second is ignored; only one redirect pulse.
